// File: rtl/edge_wave_generator_pkg.sv
// Shared state encoding and decode helpers for the edge wave generator.
// The wave level is decoded straight from the state bits, so it has no separate register.
package edge_wave_generator_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    HOLD_HI = 2'b01,
    IDLE_HI = 2'b10,
    HOLD_LO = 2'b11
  } wave_state_t;

  function automatic logic wave_of(input wave_state_t s);
    return s[0] ^ s[1];
  endfunction

  function automatic logic is_hold(input wave_state_t s);
    return s[0];
  endfunction

endpackage

// File: rtl/edge_wave_generator_if.sv
// Control/status bundle of the edge wave generator.
// Handshake: tick is a one-cycle strobe with no ready. Every high cycle is either consumed,
// queued in pending, or dropped with ovf set. en gates issue only, never queueing.
interface edge_wave_if #(
    parameter int PEND_W = 2
);
    logic              tick;
    logic              en;
    logic              clr_ovf;
    logic              wave;
    logic [PEND_W-1:0] pending;
    logic              ovf;
    logic              busy;

    modport master (
        output tick, en, clr_ovf,
        input  wave, pending, ovf, busy
    );

    modport slave (
        input  tick, en, clr_ovf,
        output wave, pending, ovf, busy
    );
endinterface

// File: rtl/edge_wave_generator_hold_timer.sv
// Minimum-hold timer: counts cycles while run is high and flags the last hold cycle.
// The counter returns to zero on done, so consecutive holds need no explicit re-arm.
module hold_timer #(
    parameter int MIN_HOLD = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic done
);
    localparam int CNT_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MIN_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;

    assign done = run && (hold_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            hold_cnt <= '0;
        end else if (run) begin
            hold_cnt <= done ? '0 : hold_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/edge_wave_generator.sv
// Turns tick strobes into level toggles on wave, holding each level at least MIN_HOLD
// cycles. Ticks that cannot be issued yet wait in a saturating pending counter.
module edge_wave_generator
  import edge_wave_generator_pkg::*;
#(
    parameter int MIN_HOLD = 3,
    parameter int PEND_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    edge_wave_if.slave  bus,
    output wave_state_t state_dbg
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    wave_state_t       state;
    wave_state_t       state_nxt;
    logic [PEND_W-1:0] pending;
    logic              ovf;
    logic              in_idle;
    logic              pend_nz;
    logic              go;
    logic              inc;
    logic              dec;
    logic              hold_done;

    assign in_idle = ~is_hold(state);
    assign pend_nz = (pending != '0);
    assign go      = in_idle & bus.en & (bus.tick | pend_nz);
    // A tick issued directly from idle with an empty queue never touches pending.
    assign inc     = bus.tick & ~(in_idle & bus.en & ~pend_nz);
    assign dec     = in_idle & bus.en & pend_nz;

    hold_timer #(.MIN_HOLD(MIN_HOLD)) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .start (go),
        .run   (is_hold(state)),
        .done  (hold_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE_LO;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE_LO: if (go)        state_nxt = HOLD_HI;
            HOLD_HI: if (hold_done) state_nxt = IDLE_HI;
            IDLE_HI: if (go)        state_nxt = HOLD_LO;
            HOLD_LO: if (hold_done) state_nxt = IDLE_LO;
            default:                state_nxt = IDLE_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else if (inc && !dec && pending != PEND_MAX) begin
            pending <= pending + 1'b1;
        end else if (dec && !inc) begin
            pending <= pending - 1'b1;
        end
    end

    // A drop in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (inc && !dec && pending == PEND_MAX) begin
            ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    assign bus.wave    = wave_of(state);
    assign bus.pending = pending;
    assign bus.ovf     = ovf;
    assign bus.busy    = is_hold(state) | pend_nz;
    assign state_dbg   = state;
endmodule

// File: tb/tb_edge_wave_generator.sv
// Directed bench for edge_wave_generator with MIN_HOLD=3, PEND_W=2, plus a loopback
// through a behavioural dual-edge detector.
module tb_edge_wave_generator;
  import edge_wave_generator_pkg::*;

  logic        clk;
  logic        rst;
  wave_state_t state_dbg;
  int          n_checks;
  int          n_pass;
  logic        prev_wave;
  int          edge_cnt;

  edge_wave_if #(.PEND_W(2)) bus ();

  edge_wave_generator #(.MIN_HOLD(3), .PEND_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // receive-side edge detector model
  always @(negedge clk) begin
    if (rst) begin
      prev_wave = 1'b0;
      edge_cnt  = 0;
    end else begin
      if (bus.wave !== prev_wave) edge_cnt++;
      prev_wave = bus.wave;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // inputs set before this call are sampled at the edge; outputs read 1ns after it
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tick = 1'b0; bus.en = 1'b1; bus.clr_ovf = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    do_reset();
    check("rst_wave", 32'(bus.wave), 0);
    check("rst_pend", 32'(bus.pending), 0);
    check("rst_ovf",  32'(bus.ovf), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_state", 32'(state_dbg), 32'(IDLE_LO));

    // 1: isolated toggle holds 3 cycles
    bus.tick = 1'b1; cycle(); bus.tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t1_wave", 32'(bus.wave), 1);
      check("t1_busy", 32'(bus.busy), 1);
      check("t1_pend", 32'(bus.pending), 0);
      cycle();
    end
    check("t1_state", 32'(state_dbg), 32'(IDLE_HI));
    check("t1_busy_end", 32'(bus.busy), 0);
    check("t1_wave_end", 32'(bus.wave), 1);

    // 2: back-to-back ticks -> second queued, wave high for 4 cycles
    do_reset();
    bus.tick = 1'b1; cycle();
    check("t2_wave_a", 32'(bus.wave), 1);
    check("t2_pend_a", 32'(bus.pending), 0);
    cycle(); bus.tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wave", 32'(bus.wave), 1);
      check("t2_pend", 32'(bus.pending), 1);
      cycle();
    end
    check("t2_wave_lo", 32'(bus.wave), 0);
    check("t2_pend_0", 32'(bus.pending), 0);
    check("t2_state", 32'(state_dbg), 32'(HOLD_LO));

    // 3: saturation, overflow, clear, clear vs drop
    do_reset();
    bus.tick = 1'b1; cycle();
    bus.en = 1'b0;
    cycle(); check("t3_pend1", 32'(bus.pending), 1);
    cycle(); check("t3_pend2", 32'(bus.pending), 2);
    cycle(); check("t3_pend3", 32'(bus.pending), 3);
    check("t3_ovf_no", 32'(bus.ovf), 0);
    cycle(); check("t3_sat", 32'(bus.pending), 3);
    check("t3_ovf", 32'(bus.ovf), 1);
    cycle(); bus.tick = 1'b0;
    check("t3_ovf_stay", 32'(bus.ovf), 1);
    check("t3_state", 32'(state_dbg), 32'(IDLE_HI));
    bus.clr_ovf = 1'b1; cycle(); bus.clr_ovf = 1'b0;
    check("t3_clr", 32'(bus.ovf), 0);
    bus.clr_ovf = 1'b1; bus.tick = 1'b1; cycle();
    bus.clr_ovf = 1'b0; bus.tick = 1'b0;
    check("t3_set_wins", 32'(bus.ovf), 1);
    cycle();
    check("t3_ovf_sticky", 32'(bus.ovf), 1);

    // 4: en=0 queues, en=1 issues from the queue
    do_reset();
    bus.en = 1'b0; bus.tick = 1'b1; cycle(); bus.tick = 1'b0;
    check("t4_wave0", 32'(bus.wave), 0);
    check("t4_pend1", 32'(bus.pending), 1);
    check("t4_busy", 32'(bus.busy), 1);
    cycle(); cycle();
    check("t4_wave_still0", 32'(bus.wave), 0);
    bus.en = 1'b1; cycle();
    check("t4_wave1", 32'(bus.wave), 1);
    check("t4_pend0", 32'(bus.pending), 0);

    // 5: reset in the middle of HOLD_HI with queued ticks
    do_reset();
    bus.tick = 1'b1; cycle(); cycle(); cycle(); bus.tick = 1'b0;
    check("t5_pre_state", 32'(state_dbg), 32'(HOLD_HI));
    check("t5_pre_pend", 32'(bus.pending), 2);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("t5_wave", 32'(bus.wave), 0);
    check("t5_pend", 32'(bus.pending), 0);
    check("t5_ovf", 32'(bus.ovf), 0);
    check("t5_busy", 32'(bus.busy), 0);

    // 6: loopback with 20 spaced random ticks
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.tick = 1'b1; cycle(); bus.tick = 1'b0;
      repeat ($urandom_range(4, 7)) cycle();
    end
    begin
      int budget;
      budget = 200;
      while (bus.busy && budget > 0) begin
        cycle();
        budget--;
      end
      check("t6_drain", 32'(bus.busy), 0);
    end
    cycle(); cycle();
    check("t6_edges", 32'(edge_cnt), 20);
    check("t6_wave", 32'(bus.wave), 0);
    check("t6_ovf", 32'(bus.ovf), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
